// File: rtl/piso_rr_scheduler.sv
// Round-robin scheduler sharing one MSB-first serializer among N_REQ requesters.
// Every output is registered; an optional idle gap separates consecutive words.
module piso_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     frame_start,
  output logic                     last_bit,
  output logic [$clog2(N_REQ)-1:0] cur_id
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int CW   = $clog2(WIDTH);
  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0]   GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : {GW{1'b0}};
  localparam logic [ID_W-1:0] PTR_RST  = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [WIDTH-1:0]  shift_r, shift_s;
  logic [CW-1:0]     bit_cnt_r, bit_cnt_s;
  logic [GW-1:0]     gap_cnt_r, gap_cnt_s;
  logic [ID_W-1:0]   ptr_r, ptr_s;
  logic [ID_W-1:0]   owner_r, owner_s;

  logic [WIDTH-1:0]  words_s [N_REQ];
  logic              win_found_s;
  logic [ID_W-1:0]   win_id_s;
  logic              arb_edge_s;
  logic              arb_go_s;

  logic [N_REQ-1:0]  grant_s;
  logic              busy_s;
  logic              serial_out_s;
  logic              serial_valid_s;
  logic              frame_start_s;
  logic              last_bit_s;
  logic [ID_W-1:0]   cur_id_s;

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words_s[i] = data_in[i*WIDTH +: WIDTH];
    end
  end

  // Rotating priority search: start just after the last winner and wrap.
  always_comb begin
    logic [ID_W-1:0] idx_v;
    logic            hit_v;
    win_found_s = 1'b0;
    win_id_s    = {ID_W{1'b0}};
    idx_v       = {ID_W{1'b0}};
    hit_v       = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_v       = ID_W'((int'(ptr_r) + i) % N_REQ);
      hit_v       = req[idx_v] & ~win_found_s;
      win_id_s    = hit_v ? idx_v : win_id_s;
      win_found_s = win_found_s | hit_v;
    end
  end

  // Next-state logic; the word-boundary edges double as arbitration edges.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_cnt_s  = bit_cnt_r;
    gap_cnt_s  = gap_cnt_r;
    ptr_s      = ptr_r;
    owner_s    = owner_r;
    grant_s    = {N_REQ{1'b0}};
    arb_edge_s = 1'b0;
    arb_go_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        arb_edge_s = 1'b1;
      end
      S_SHIFT: begin
        if (bit_cnt_r == {CW{1'b0}}) begin
          if (GAP > 0) begin
            state_s   = S_GAP;
            gap_cnt_s = GAP_LOAD;
          end else begin
            state_s    = S_IDLE;
            arb_edge_s = 1'b1;
          end
        end else begin
          shift_s   = {shift_r[WIDTH-2:0], 1'b0};
          bit_cnt_s = bit_cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (gap_cnt_r == {GW{1'b0}}) begin
          state_s    = S_IDLE;
          arb_edge_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r - {{(GW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    if (arb_edge_s && en && win_found_s) begin
      arb_go_s  = 1'b1;
      state_s   = S_SHIFT;
      shift_s   = words_s[win_id_s];
      bit_cnt_s = CNT_LOAD;
      ptr_s     = win_id_s;
      owner_s   = win_id_s;
      grant_s   = {{(N_REQ-1){1'b0}}, 1'b1} << win_id_s;
    end else begin
      arb_go_s = 1'b0;
    end
  end

  // Output values are derived from the next state so they can be registered.
  always_comb begin
    serial_valid_s = (state_s == S_SHIFT);
    busy_s         = (state_s != S_IDLE);
    serial_out_s   = serial_valid_s & shift_s[WIDTH-1];
    frame_start_s  = arb_go_s;
    last_bit_s     = serial_valid_s && (bit_cnt_s == {CW{1'b0}});
    cur_id_s       = serial_valid_s ? owner_s : {ID_W{1'b0}};
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      shift_r   <= {WIDTH{1'b0}};
      bit_cnt_r <= {CW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
      ptr_r     <= PTR_RST;
      owner_r   <= {ID_W{1'b0}};
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      ptr_r     <= ptr_s;
      owner_r   <= owner_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant        <= {N_REQ{1'b0}};
      busy         <= 1'b0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      last_bit     <= 1'b0;
      cur_id       <= {ID_W{1'b0}};
    end else begin
      grant        <= grant_s;
      busy         <= busy_s;
      serial_out   <= serial_out_s;
      serial_valid <= serial_valid_s;
      frame_start  <= frame_start_s;
      last_bit     <= last_bit_s;
      cur_id       <= cur_id_s;
    end
  end

endmodule
